instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Instruction fetch stage sitting directly upstream of the control unit. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and presents each fetched instruction word (opcode in bits [INSTR_W-1:INSTR_W-8]) with its PC to decode over a valid/ready handshake. Accepts PC redirects from the jump path and the decoded halt signal.

Parameters:
ADDR_W, 16, PC / instruction memory address width
INSTR_W, 32, instruction word width (opcode = top 8 bits)
RESET_PC, 0, PC value loaded on reset
PC_STEP, 1, PC increment per instruction (word addressed)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
imem_req  out  1  memory read request; held high until imem_ack
imem_addr  out  ADDR_W  read address, stable while imem_req high
imem_ack  in  1  read complete; imem_rdata valid this cycle
imem_rdata  in  INSTR_W  read data
instr_valid  out  1  instr/instr_pc valid for decode
instr_ready  in  1  decode accepts instruction
instr  out  INSTR_W  fetched instruction word
instr_pc  out  ADDR_W  PC of instr
redirect_valid  in  1  one-cycle jump request
redirect_pc  in  ADDR_W  jump target
halt_in  in  1  halt from decoded control signals
halted  out  1  fetch stopped
fetch_count  out  32  retired-fetch counter (only with FETCH_PERF_EN)

Behaviour:
- All outputs registered. Reset: pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0, drop flags cleared. First request issues on the first clk edge after rst deasserts.
- States: FETCH, HOLD, DRAIN, HALTED.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+PC_STEP (mod 2^ADDR_W), imem_req<=0, go HOLD.
- HOLD: instr/instr_pc/instr_valid stable until instr_valid&&instr_ready. Then instr_valid<=0 and go FETCH; the next request is raised the following cycle. Peak throughput is 1 instruction per 2 cycles when imem acks in the request's first cycle.
- Memory protocol: a raised request is never withdrawn before imem_ack. imem_addr never changes while imem_req=1.
- Redirect (redirect_valid=1), in any non-HALTED state: pc<=redirect_pc and instr_valid<=0 (any held instruction is discarded, even if instr_ready=1 that cycle).
  - In FETCH without ack: go DRAIN. Keep req/addr until ack, discard that data, then go FETCH at redirect_pc.
  - In FETCH with ack the same cycle: discard rdata, go FETCH at redirect_pc.
  - In HOLD: go FETCH at redirect_pc.
  - A second redirect during DRAIN overwrites the target pc.
- Halt (halt_in=1) takes priority over a simultaneous redirect, which is ignored. instr_valid<=0.
  - If a request is outstanding without ack: go DRAIN with halt_pending set; on ack, discard and go HALTED.
  - Otherwise go HALTED immediately.
- HALTED: imem_req=0, instr_valid=0, halted=1. redirect_valid and halt_in are ignored. Exit only via rst.
- rst mid-request: all state is cleared immediately. Memory-side cleanup is the memory's responsibility.

Optional Feature:
FETCH_PERF_EN: when defined, adds output fetch_count, 32-bit, reset 0. It increments by 1 on each instr_valid&&instr_ready handshake not cancelled by a same-cycle redirect or halt, and wraps from 0xFFFFFFFF to 0. When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, RESET_PC=0x0000, memory acks same cycle, instr_ready=1 -> imem_addr sequence 0,1,2,3. Each instr handshake carries instr_pc 0,1,2,3 spaced 2 cycles apart.
- Memory ack delayed 3 cycles, word 0xA0120005 -> imem_req/imem_addr held 3 cycles. Then instr=0xA0120005, instr_pc=0, instr_valid=1.
- instr_ready=0 for 5 cycles after a fetch -> instr_valid, instr and instr_pc unchanged for 5 cycles, no new imem_req.
- Redirect to 0x0040 while a request to 0x0003 waits for ack -> req to 0x0003 held until ack, its data never appears on instr. The next request is to 0x0040 and the next instr_pc is 0x0040.
- halt_in with a simultaneous redirect to 0x0080 while in HOLD -> instr_valid=0, halted=1 the next cycle, no further imem_req, no request to 0x0080. rst restores fetching from RESET_PC.
- pc=0xFFFF, ADDR_W=16 -> after that fetch the next imem_addr=0x0000. With FETCH_PERF_EN, fetch_count increments per accepted instruction.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads imem over req/ack and hands words to decode over valid/ready.
// Define FETCH_PERF_EN to add the fetch_count output (accepted-instruction counter).
module instr_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_in,
    output logic               halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_count
`endif
);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN, S_HALTED} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                imem_req_q, imem_req_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic                instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic                halted_q, halted_d;
    logic                halt_pend_q, halt_pend_d;
    logic                drain_halt;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        halted_d      = halted_q;
        halt_pend_d   = halt_pend_q;
        drain_halt    = halt_pend_q | halt_in;

        case (state_q)
            S_FETCH: begin
                if (halt_in) begin
                    if (imem_req_q && !imem_ack) begin
                        state_d     = S_DRAIN;
                        halt_pend_d = 1'b1;
                    end else begin
                        state_d    = S_HALTED;
                        imem_req_d = 1'b0;
                        halted_d   = 1'b1;
                    end
                end else if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (imem_req_q && !imem_ack) begin
                        state_d = S_DRAIN;
                    end else if (imem_req_q) begin
                        // Word acked this cycle belongs to the old path; drop it and re-request.
                        imem_req_d = 1'b0;
                    end else begin
                        imem_req_d  = 1'b1;
                        imem_addr_d = redirect_pc;
                    end
                end else if (!imem_req_q) begin
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_q;
                end else if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + ADDR_W'(PC_STEP);
                    imem_req_d    = 1'b0;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (halt_in) begin
                    instr_valid_d = 1'b0;
                    halted_d      = 1'b1;
                    state_d       = S_HALTED;
                end else if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    pc_d          = redirect_pc;
                    imem_req_d    = 1'b1;
                    imem_addr_d   = redirect_pc;
                    state_d       = S_FETCH;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    imem_req_d    = 1'b1;
                    imem_addr_d   = pc_q;
                    state_d       = S_FETCH;
                end
            end
            S_DRAIN: begin
                // Request stays up until acked; its data is never used.
                if (!drain_halt && redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    imem_req_d  = 1'b0;
                    halt_pend_d = 1'b0;
                    if (drain_halt) begin
                        state_d  = S_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    halt_pend_d = drain_halt;
                end
            end
            S_HALTED: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
                halted_d      = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            halted_q      <= 1'b0;
            halt_pend_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            halted_q      <= halted_d;
            halt_pend_q   <= halt_pend_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign halted      = halted_q;

`ifdef FETCH_PERF_EN
    logic        hs_fire;
    logic [31:0] fetch_count_q, fetch_count_d;

    // Only a handshake that is not cancelled by a same-cycle redirect or halt retires.
    assign hs_fire = (state_q == S_HOLD) && instr_valid_q && instr_ready && !redirect_valid && !halt_in;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (hs_fire) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed stimulus, a memory responder and a transaction-level model.
module tb_instr_fetch;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halt_in;
    logic               halted;
`ifdef FETCH_PERF_EN
    logic [31:0]        fetch_count;
`endif

    instr_fetch #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(16'h0000), .PC_STEP(1)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_in(halt_in), .halted(halted)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int lat    = 0;
    int cyc_n  = 0;

    logic [15:0] hs_pc[$];
    int          hs_cyc[$];
    logic [15:0] rise_addr[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_data(input logic [15:0] a);
        return 32'hA0120005 + {a, 16'h0000};
    endfunction

    function automatic logic [31:0] hs_at(input int i);
        if (i < hs_pc.size()) return {16'h0000, hs_pc[i]};
        return 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] rise_at(input int i);
        if (i < rise_addr.size()) return {16'h0000, rise_addr[i]};
        return 32'hDEADBEEF;
    endfunction

    function automatic int gap_at(input int i);
        if (i < hs_cyc.size() && i > 0) return hs_cyc[i] - hs_cyc[i-1];
        return -1;
    endfunction

    // Memory: acks a request once it has waited lat cycles.
    initial begin
        int cnt;
        cnt = 0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !imem_req) begin
                imem_ack = 1'b0;
                cnt = 0;
            end else if (cnt >= lat) begin
                imem_ack = 1'b1;
                imem_rdata = mem_data(imem_addr);
                cnt = 0;
            end else begin
                imem_ack = 1'b0;
                cnt++;
            end
        end
    end

    // Model: expected next PC from the fetch/redirect/halt rules, plus protocol invariants.
    initial begin
        logic [15:0]  exp_pc, prev_addr, prev_pc;
        logic [31:0]  prev_instr, mcount;
        logic         mhalt, prev_req, prev_ack, prev_hold;
        int           hw;
        exp_pc = 16'h0000; mhalt = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; prev_hold = 1'b0;
        prev_addr = '0; prev_pc = '0; prev_instr = '0; mcount = '0; hw = 0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (rst) begin
                chk("rst_req", imem_req, 0);
                chk("rst_valid", instr_valid, 0);
                chk("rst_halted", halted, 0);
                exp_pc = 16'h0000; mhalt = 1'b0; prev_req = 1'b0; prev_hold = 1'b0; mcount = '0; hw = 0;
            end else begin
                if (prev_req && !prev_ack) begin
                    chk("req_held", imem_req, 1);
                    chk("addr_stable", imem_addr, prev_addr);
                end
                if (prev_hold) begin
                    chk("hold_valid", instr_valid, 1);
                    chk("hold_instr", instr, prev_instr);
                    chk("hold_pc", instr_pc, prev_pc);
                end
                if (imem_req && !prev_req) begin
                    rise_addr.push_back(imem_addr);
                    chk("req_addr", imem_addr, exp_pc);
                    chk("req_after_halt", mhalt, 0);
                end
                if (instr_valid) chk("instr_data", instr, mem_data(instr_pc));
`ifdef FETCH_PERF_EN
                chk("fetch_count", fetch_count, mcount);
`endif
                if (!mhalt) begin
                    chk("halted_early", halted, 0);
                end else begin
                    chk("valid_after_halt", instr_valid, 0);
                    if (halted) chk("req_while_halted", imem_req, 0);
                    else begin
                        hw++;
                        if (hw == 12) chk("halt_latency", halted, 1);
                    end
                end
                prev_hold = instr_valid && !instr_ready && !redirect_valid && !halt_in && !mhalt;
                if (!mhalt) begin
                    if (halt_in) begin
                        mhalt = 1'b1;
                        hw = 0;
                    end else begin
                        if (instr_valid && instr_ready && !redirect_valid) begin
                            chk("hs_pc", instr_pc, exp_pc);
                            hs_pc.push_back(instr_pc);
                            hs_cyc.push_back(cyc_n);
                            exp_pc = exp_pc + 16'd1;
                            mcount = mcount + 32'd1;
                        end
                        if (redirect_valid) exp_pc = redirect_pc;
                    end
                end
                prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
                prev_instr = instr; prev_pc = instr_pc;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_hs(input string name, input int target, input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            cyc();
            if (hs_pc.size() >= target) break;
        end
        if (k == bound) chk(name, hs_pc.size(), target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, r0, n, ok;
        rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_in = 1'b0; lat = 0;
        cyc(); cyc();
        chk("reset_req", imem_req, 0);
        chk("reset_addr", imem_addr, 16'h0000);
        chk("reset_valid", instr_valid, 0);
        chk("reset_instr", instr, 0);
        chk("reset_instr_pc", instr_pc, 0);
        chk("reset_halted", halted, 0);

        // Back-to-back fetch with same-cycle ack.
        instr_ready = 1'b1; lat = 0;
        h0 = hs_pc.size(); r0 = rise_addr.size();
        rst = 1'b0;
        wait_hs("t1_timeout", h0 + 4, 30);
        for (int i = 0; i < 4; i++) begin
            chk("t1_hs_pc", hs_at(h0 + i), i);
            chk("t1_req_addr", rise_at(r0 + i), i);
            if (i > 0) chk("t1_hs_gap", gap_at(h0 + i), 2);
        end
`ifdef FETCH_PERF_EN
        chk("t1_fetch_count", fetch_count, 4);
`endif

        // Delayed ack, then decode stalls for 5 cycles.
        rst = 1'b1; lat = 3; instr_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        n = 0; ok = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (imem_req && !imem_ack) n++;
            if (instr_valid) begin ok = 1; break; end
        end
        chk("t2_wait_cycles", n, 3);
        chk("t2_valid", instr_valid, 1);
        chk("t2_instr", instr, 32'hA0120005);
        chk("t2_instr_pc", instr_pc, 16'h0000);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t2_stall_valid", instr_valid, 1);
            chk("t2_stall_instr", instr, 32'hA0120005);
            chk("t2_stall_pc", instr_pc, 16'h0000);
            chk("t2_stall_noreq", imem_req, 0);
        end

        // Redirect discards a held word even with ready high; second redirect drains the pending read.
        redirect_valid = 1'b1; redirect_pc = 16'h0003; instr_ready = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        chk("t3_req", imem_req, 1);
        chk("t3_addr", imem_addr, 16'h0003);
        chk("t3_valid_dropped", instr_valid, 0);
        cyc();
        r0 = rise_addr.size();
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        cyc();
        redirect_valid = 1'b0;
        chk("t3_drain_req", imem_req, 1);
        chk("t3_drain_addr", imem_addr, 16'h0003);
        ok = 0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (instr_valid) begin ok = 1; break; end
        end
        chk("t3_valid", ok, 1);
        chk("t3_next_req", rise_at(r0), 16'h0040);
        chk("t3_instr_pc", instr_pc, 16'h0040);
        chk("t3_instr", instr, 32'hA0520005);

        // Halt wins over a simultaneous redirect in HOLD.
        halt_in = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0080; instr_ready = 1'b1;
        cyc();
        halt_in = 1'b0; redirect_valid = 1'b0;
        chk("t4_valid", instr_valid, 0);
        chk("t4_halted", halted, 1);
        chk("t4_req", imem_req, 0);
        for (int k = 0; k < 4; k++) begin
            redirect_valid = (k == 1);
            cyc();
            chk("t4_halted_hold", halted, 1);
            chk("t4_noreq", imem_req, 0);
        end
        redirect_valid = 1'b0;

        // Reset leaves HALTED and restarts at RESET_PC.
        rst = 1'b1; lat = 0;
        cyc();
        chk("t5_halted_clr", halted, 0);
        r0 = rise_addr.size();
        rst = 1'b0;
        cyc(); cyc();
        chk("t5_restart_addr", rise_at(r0), 16'h0000);
        chk("t5_halted", halted, 0);

        // PC wraps from 0xFFFF to 0x0000.
        cyc(); cyc(); cyc();
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        cyc();
        redirect_valid = 1'b0;
        h0 = hs_pc.size(); r0 = rise_addr.size();
        wait_hs("t6_timeout", h0 + 2, 30);
        chk("t6_hs_ffff", hs_at(h0), 16'hFFFF);
        chk("t6_hs_wrap", hs_at(h0 + 1), 16'h0000);
        chk("t6_req_ffff", rise_at(r0), 16'hFFFF);
        chk("t6_req_wrap", rise_at(r0 + 1), 16'h0000);

        // Halt while a request waits for its ack.
        rst = 1'b1; lat = 3; instr_ready = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        halt_in = 1'b1;
        cyc();
        halt_in = 1'b0;
        chk("t7_req_held", imem_req, 1);
        chk("t7_not_yet_halted", halted, 0);
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (halted) break;
        end
        chk("t7_halted", halted, 1);
        chk("t7_req", imem_req, 0);
        chk("t7_valid", instr_valid, 0);
        cyc(); cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
